fan_speed_commander: RTL and testbench
======================================

# fan_speed_commander

Command-side driver for the fan controller's `update`/`up`/`down` interface. The block accepts a requested target speed (0–3) through a req/busy/done handshake. It then issues single-cycle update strobes, each carrying `up` or `down`, until its internal mirror of the fan speed equals the target. Strobes are spaced by a programmable gap. The block sits between the control/UI logic and the fan controller, and shares the controller's clock and reset.

## Interface
Parameters:
- `GAP_CYCLES`, default 4: idle cycles between consecutive update strobes. Legal range is 1–255.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  1: start request. Sampled only in IDLE.
- `target`  in  2: requested speed (0 = stop, 1 = slow, 2 = med, 3 = fast). Latched when `req` is accepted.
- `busy`  out  1: high from the cycle after acceptance until the cycle `done` is high, inclusive.
- `done`  out  1: one-cycle pulse when the mirror equals the latched target.
- `update`  out  1: strobe to the fan controller. High for exactly one cycle per step.
- `up`  out  1: step-up qualifier. Valid only while `update` is high, 0 otherwise.
- `down`  out  1: step-down qualifier. Valid only while `update` is high, 0 otherwise.
- `speed_model`  out  2: mirrored fan speed, updated at the edge ending each strobe.

## Operation
- All outputs are registered.
- Reset value is 0 for every output: `busy`, `done`, `update`, `up`, `down`, and `speed_model` = 0 (stop). The FSM resets to IDLE.
- FSM states: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - `req` = 1 latches `target` into `target_q`.
  - If `target` == `speed_model`, go to DONE.
  - Otherwise go to ISSUE.
  - `req` in any other state is ignored and not queued.
- ISSUE (1 cycle):
  - `update` = 1.
  - `up` = 1 if `target_q` > `speed_model`, else `down` = 1.
  - At the edge ending ISSUE, `speed_model` increments or decrements by 1, the gap counter loads `GAP_CYCLES`, and the FSM goes to GAP.
- GAP:
  - Counter decrements each cycle.
  - After `GAP_CYCLES` cycles, go to DONE if `speed_model` == `target_q`, else go to ISSUE.
- DONE (1 cycle): `done` = 1, `busy` = 1, then go to IDLE.
- Arithmetic is 2-bit unsigned.
  - `up` is never issued at speed 3 and `down` is never issued at speed 0.
  - No wrap-around is possible by construction.
  - `up` and `down` are mutually exclusive except as described under Configuration.
- Reset mid-operation forces IDLE and zeroes all outputs, including `speed_model`, on the next edge. A strobe in flight is dropped. This matches the fan controller, which also returns to stop on reset.
- `target` changes after acceptance have no effect until the next request.

## Timing
- Let `req` be accepted in cycle T, and let n = |target − speed_model| steps.
- Strobe k (k = 0..n−1) is high in cycle T+1+k·(GAP_CYCLES+1).
- `done` is high in cycle T+1+n·(GAP_CYCLES+1).
- For n = 0, `done` is high in T+1 and no strobe is issued.
- `busy` is high from T+1 through the `done` cycle. The next `req` is accepted no earlier than the cycle after `done`.
- `speed_model` shows the new value in the cycle after each strobe, which is the same edge at which the fan controller changes state.

## Configuration
- `FAN_CMD_FAST_STOP_EN` defined:
  - A request with `target` = 0 and `speed_model` ≠ 0 issues one strobe with `up` = `down` = 1.
  - `speed_model` goes to 0 at the edge ending that strobe.
  - `done` is high in T+1+(GAP_CYCLES+1) regardless of the starting speed.
- `FAN_CMD_FAST_STOP_EN` not defined:
  - Stop requests step down one level per strobe like any other target.
  - `up` and `down` are never high together.

## Structure
- Package `fan_pkg` holds:
  - speed constants `SPEED_STOP` = 0, `SPEED_SLOW` = 1, `SPEED_MED` = 2, `SPEED_FAST` = 3;
  - the commander FSM state encoding;
  - the 2-bit speed typedef.
- One sub-module, `fan_step_timer`:
  - loadable 8-bit down-counter with `load`, `load_val`, and `expired` outputs;
  - used for the GAP interval.

## Test plan
- Reset, then `req` with `target` = 0: `done` in T+1, no `update` strobe, `busy` high only in T+1, `speed_model` = 0.
- From 0, `req` with `target` = 3 and `GAP_CYCLES` = 4: three `up` strobes at T+1, T+6, T+11; `done` at T+16; `speed_model` sequence 1, 2, 3. A fan controller instance in the bench reports speed 3.
- From 3, `target` = 1: two `down` strobes at T+1 and T+6, `done` at T+11, `speed_model` = 1.
- From 3, `target` = 0:
  - with `FAN_CMD_FAST_STOP_EN` defined: one strobe with `up` = `down` = 1 at T+1, `done` at T+6;
  - without it: three `down` strobes, `done` at T+16.
- `req` pulsed while `busy` with a different target: ignored, and the original sequence completes unchanged.
- `reset` asserted in the GAP state after the first `up` strobe: all outputs 0 next cycle, FSM in IDLE, a fresh `req` is accepted normally.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared types and constants for the fan command path: speed encoding,
// commander FSM states and the step-direction helper.
package fan_pkg;

    typedef logic [1:0] speed_t;

    localparam speed_t SPEED_STOP = 2'd0;
    localparam speed_t SPEED_SLOW = 2'd1;
    localparam speed_t SPEED_MED  = 2'd2;
    localparam speed_t SPEED_FAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } cmd_state_t;

    // True when reaching tgt from cur needs an up step.
    function automatic logic step_up(input speed_t tgt, input speed_t cur);
        return tgt > cur;
    endfunction

endpackage

// File: rtl/fan_step_timer.sv
// Loadable 8-bit down-counter timing the idle gap between update strobes.
// expired flags the last cycle of a loaded interval.
module fan_step_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    // A value of 1 means this is the final gap cycle; the counter parks at 0.
    assign expired = (count_reg == 8'd1);

endmodule

// File: rtl/fan_speed_commander.sv
// Drives the fan controller's update/up/down strobes until a mirrored speed
// reaches the requested target. Optional macro: FAN_CMD_FAST_STOP_EN.
module fan_speed_commander
    import fan_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] target,
    output logic       busy,
    output logic       done,
    output logic       update,
    output logic       up,
    output logic       down,
    output logic [1:0] speed_model
);

    cmd_state_t state_reg, state_next;
    speed_t     target_reg, target_next;
    speed_t     speed_reg, speed_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       update_reg, update_next;
    logic       up_reg, up_next;
    logic       down_reg, down_next;

    logic       timer_load;
    logic       timer_expired;
    logic       go_issue;
    speed_t     dir_tgt;

    fan_step_timer u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (8'(GAP_CYCLES)),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        speed_next  = speed_reg;
        update_next = 1'b0;
        up_next     = 1'b0;
        down_next   = 1'b0;
        timer_load  = 1'b0;
        go_issue    = 1'b0;
        // In IDLE the target has not been latched yet, so steer from the input.
        dir_tgt     = (state_reg == ST_IDLE) ? target : target_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    target_next = target;
                    if (target == speed_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        go_issue = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                timer_load = 1'b1;
                state_next = ST_GAP;
`ifdef FAN_CMD_FAST_STOP_EN
                if (up_reg && down_reg) begin
                    speed_next = SPEED_STOP;
                end else
`endif
                if (up_reg) begin
                    speed_next = speed_reg + 2'd1;
                end else begin
                    speed_next = speed_reg - 2'd1;
                end
            end
            ST_GAP: begin
                if (timer_expired) begin
                    if (speed_reg == target_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        go_issue = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (go_issue) begin
            state_next  = ST_ISSUE;
            update_next = 1'b1;
`ifdef FAN_CMD_FAST_STOP_EN
            if (dir_tgt == SPEED_STOP) begin
                up_next   = 1'b1;
                down_next = 1'b1;
            end else begin
                up_next   = step_up(dir_tgt, speed_reg);
                down_next = ~step_up(dir_tgt, speed_reg);
            end
`else
            up_next   = step_up(dir_tgt, speed_reg);
            down_next = ~step_up(dir_tgt, speed_reg);
`endif
        end

        // Outputs are registered, so they are derived from the state being entered.
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            target_reg <= SPEED_STOP;
            speed_reg  <= SPEED_STOP;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            update_reg <= 1'b0;
            up_reg     <= 1'b0;
            down_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            speed_reg  <= speed_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            update_reg <= update_next;
            up_reg     <= up_next;
            down_reg   <= down_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign update      = update_reg;
    assign up          = up_reg;
    assign down        = down_reg;
    assign speed_model = speed_reg;

endmodule

// File: tb/tb_fan_speed_commander.sv
// Directed bench for fan_speed_commander with a behavioural fan controller
// following the strobes; honours FAN_CMD_FAST_STOP_EN when defined.
module tb_fan_speed_commander;
    import fan_pkg::*;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [1:0] target;
    logic       busy, done, update, up, down;
    logic [1:0] speed_model;
    logic [1:0] fan_spd;
    logic [1:0] exp_speed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fan_speed_commander #(.GAP_CYCLES(G)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .target      (target),
        .busy        (busy),
        .done        (done),
        .update      (update),
        .up          (up),
        .down        (down),
        .speed_model (speed_model)
    );

    // Reference fan controller reacting to the strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            fan_spd <= 2'd0;
        end else if (update) begin
            if (up && down)                 fan_spd <= 2'd0;
            else if (up && fan_spd != 2'd3) fan_spd <= fan_spd + 2'd1;
            else if (down && fan_spd != 2'd0) fan_spd <= fan_spd - 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},   8'(busy),   8'd0);
        chk({tag, ".done"},   8'(done),   8'd0);
        chk({tag, ".update"}, 8'(update), 8'd0);
        chk({tag, ".up"},     8'(up),     8'd0);
        chk({tag, ".down"},   8'(down),   8'd0);
    endtask

    // Issue one request and check every cycle from T+1 through done and one beyond.
    task automatic do_req(input string tag, input logic [1:0] tgt, input int n,
                          input logic dup, input logic ddn, input bit fast, input bit inject);
        int  last;
        bit  strobe;
        last = n * (G + 1) + 1;
        @(negedge clk);
        req    = 1'b1;
        target = tgt;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            #1;
            strobe = (c < last) && (((c - 1) % (G + 1)) == 0);
            chk({tag, ".update"}, 8'(update),      8'(strobe));
            chk({tag, ".up"},     8'(up),          8'(strobe && dup));
            chk({tag, ".down"},   8'(down),        8'(strobe && ddn));
            chk({tag, ".busy"},   8'(busy),        8'd1);
            chk({tag, ".done"},   8'(done),        8'(c == last));
            chk({tag, ".speed"},  8'(speed_model), 8'(exp_speed));
            @(negedge clk);
            req    = inject && (c == 3);
            target = 2'($urandom_range(0, 3));
            if (strobe) begin
                if (fast)     exp_speed = 2'd0;
                else if (dup) exp_speed = exp_speed + 2'd1;
                else          exp_speed = exp_speed - 2'd1;
            end
            @(posedge clk);
        end
        #1;
        chk_idle_outputs({tag, ".after"});
        chk({tag, ".speed_end"}, 8'(speed_model), 8'(exp_speed));
        chk({tag, ".fan"},       8'(fan_spd),     8'(exp_speed));
        $display("req %s target=%0d steps=%0d final_speed=%0d", tag, tgt, n, speed_model);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        target    = 2'd0;
        exp_speed = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset.speed", 8'(speed_model), 8'd0);
        chk("reset.state", 8'(dut.state_reg), 8'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;

        do_req("zero_to_0", 2'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req("0_to_3",    2'd3, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        do_req("3_to_1",    2'd1, 2, 1'b0, 1'b1, 1'b0, 1'b1);
        do_req("1_to_3",    2'd3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FAN_CMD_FAST_STOP_EN
        do_req("3_to_0",    2'd0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
`else
        do_req("3_to_0",    2'd0, 3, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Reset during GAP after the first up strobe.
        @(negedge clk);
        req    = 1'b1;
        target = 2'd2;
        @(posedge clk);
        #1;
        chk("rst_mid.update", 8'(update), 8'd1);
        chk("rst_mid.up",     8'(up),     8'd1);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.gap_speed", 8'(speed_model), 8'd1);
        chk("rst_mid.gap_state", 8'(dut.state_reg), 8'(ST_GAP));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("rst_mid.out");
        chk("rst_mid.speed", 8'(speed_model), 8'd0);
        chk("rst_mid.state", 8'(dut.state_reg), 8'(ST_IDLE));
        chk("rst_mid.fan",   8'(fan_spd), 8'd0);
        $display("reset mid-gap speed=%0d busy=%0d", speed_model, busy);
        @(negedge clk);
        reset     = 1'b0;
        exp_speed = 2'd0;
        do_req("after_rst", 2'd1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
